pe_mac_acc: RTL

- Parametrised successor to the single-multiply PE: a multiply-accumulate processing engine that computes one dot product per job.
- Weights are preloaded into an internal register-file scratchpad. Input activations (iacts) stream into an internal FIFO.
- Each job multiplies cfg_num_ch iacts by weights 0..cfg_num_ch-1, accumulates the products into a signed partial sum, and emits it on a valid/ready output.
- Sits in the PE array between the iact distribution network and the psum collection path.

---
 rtl/pe_mac_acc.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pe_mac_acc.sv
// Purpose : multiply-accumulate PE computing one signed dot product per job
//           (iact FIFO x preloaded weight scratchpad) for the PE array.
// Latency : N+2 cycles from start to psum_valid with a prefilled FIFO;
//           2 cycles from the last iact pop to psum_valid.
// Backpressure: iact_ready drops while the FIFO is full; the result is held
//           in DONE (valid/dout stable) until psum_ready.
//
// Ports (pe_mac_acc):
//   clk, rstN                 rising-edge clock, synchronous active-low reset
//   start, cfg_num_ch         job start (IDLE only), channel count sampled on start
//   wght_we/addr/din          weight scratchpad write port (IDLE only)
//   iact_valid/din/ready      iact push interface into the FIFO
//   psum_valid/dout/ready     result handshake
//   busy                      high whenever the engine is not IDLE
//   fifo_count                current iact FIFO occupancy
//   psum_sat                  sticky saturation flag (PE_MAC_ACC_SATURATE_EN only)
//
// Build option: define PE_MAC_ACC_SATURATE_EN to make every accumulate step
// saturate instead of wrap and to add the psum_sat output.

// Generic synchronous FIFO used for the iact queue.
// Latency: pushed data visible at the head one cycle after the push.
// Backpressure: wr_rdy low when full; a pop in a full cycle still happens.
module pe_mac_acc_fifo #(
   parameter int DAT_W  = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              wr_vld,
   output logic              wr_rdy,
   input  logic [DAT_W-1:0]  wr_dat,
   output logic              rd_vld,
   input  logic              rd_rdy,
   output logic [DAT_W-1:0]  rd_dat,
   output logic [ADDR_W:0]   count
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   logic [DAT_W-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              push;
   logic              pop;

   assign wr_rdy = (count != FULL_CNT);
   assign rd_vld = (count != '0);
   assign push   = wr_vld && wr_rdy;
   assign pop    = rd_vld && rd_rdy;
   assign rd_dat = mem[rd_ptr];

   // Pointers are exactly ADDR_W bits wide, so they wrap modulo DEPTH.
   always_ff @(posedge clk) begin
      if (!rstN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_dat;
   end

endmodule

module pe_mac_acc #(
   parameter int DATA_BITWIDTH      = 8,
   parameter int NUM_OF_CHANNEL     = 32,
   parameter int WGHT_ADDR_BITWIDTH = 5,
   parameter int FIFO_ADDR_BITWIDTH = 4,
   parameter int PSUM_BITWIDTH      = 21,
   parameter int CH_CNT_BITWIDTH    = 6
) (
   input  logic                          clk,
   input  logic                          rstN,
   input  logic                          start,
   input  logic [CH_CNT_BITWIDTH-1:0]    cfg_num_ch,
   input  logic                          wght_we,
   input  logic [WGHT_ADDR_BITWIDTH-1:0] wght_addr,
   input  logic [DATA_BITWIDTH-1:0]      wght_din,
   input  logic                          iact_valid,
   input  logic [DATA_BITWIDTH-1:0]      iact_din,
   output logic                          iact_ready,
   output logic                          psum_valid,
   output logic [PSUM_BITWIDTH-1:0]      psum_dout,
   input  logic                          psum_ready,
   output logic                          busy,
`ifdef PE_MAC_ACC_SATURATE_EN
   output logic                          psum_sat,
`endif
   output logic [FIFO_ADDR_BITWIDTH:0]   fifo_count
);

   localparam int WGHT_DEPTH = 1 << WGHT_ADDR_BITWIDTH;
   localparam int PROD_W     = 2 * DATA_BITWIDTH;
   localparam logic [CH_CNT_BITWIDTH-1:0] NCH_MAX = CH_CNT_BITWIDTH'(NUM_OF_CHANNEL);
   localparam logic [CH_CNT_BITWIDTH-1:0] CH_ONE  = CH_CNT_BITWIDTH'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t state_q;
   state_t state_d;

   // ---------------------------------------------------------------
   // iact FIFO: pushes in any state, pops only while accumulating
   // ---------------------------------------------------------------
   logic                            fifo_rd_vld;
   logic                            fifo_rd_rdy;
   logic signed [DATA_BITWIDTH-1:0] iact_head;
   logic                            pop;
   logic                            last_pop;

   assign fifo_rd_rdy = (state_q == S_ACCUM);
   assign pop         = fifo_rd_vld && fifo_rd_rdy;

   pe_mac_acc_fifo #(
      .DAT_W  (DATA_BITWIDTH),
      .ADDR_W (FIFO_ADDR_BITWIDTH)
   ) u_iact_fifo (
      .clk    (clk),
      .rstN   (rstN),
      .wr_vld (iact_valid),
      .wr_rdy (iact_ready),
      .wr_dat (iact_din),
      .rd_vld (fifo_rd_vld),
      .rd_rdy (fifo_rd_rdy),
      .rd_dat (iact_head),
      .count  (fifo_count)
   );

   // ---------------------------------------------------------------
   // Weight scratchpad: writable only while IDLE so a running job
   // always sees a stable weight set. Contents are never reset.
   // ---------------------------------------------------------------
   logic signed [DATA_BITWIDTH-1:0] wght_mem [WGHT_DEPTH];
   logic signed [DATA_BITWIDTH-1:0] wght_rd;

   always_ff @(posedge clk) begin
      if (wght_we && (state_q == S_IDLE)) wght_mem[wght_addr] <= wght_din;
   end

   // ---------------------------------------------------------------
   // Job control registers
   // ---------------------------------------------------------------
   logic [CH_CNT_BITWIDTH-1:0] ch_cnt_q;
   logic [CH_CNT_BITWIDTH-1:0] n_q;
   logic [CH_CNT_BITWIDTH-1:0] n_eff;
   logic                       job_start;

   assign job_start = (state_q == S_IDLE) && start;

   // A zero count means "full job"; oversize requests are clamped.
   assign n_eff = ((cfg_num_ch == '0) || (cfg_num_ch > NCH_MAX)) ? NCH_MAX : cfg_num_ch;

   assign wght_rd  = wght_mem[ch_cnt_q[WGHT_ADDR_BITWIDTH-1:0]];
   assign last_pop = pop && (ch_cnt_q == (n_q - CH_ONE));

   // ---------------------------------------------------------------
   // Two-stage datapath: product register, then accumulate. The
   // product valid bit only follows real pops, so an empty-FIFO stall
   // inserts no extra add and costs no cycle once data returns.
   // ---------------------------------------------------------------
   logic signed [PROD_W-1:0]        prod_d;
   logic signed [PROD_W-1:0]        prod_q;
   logic                            prod_vld_q;
   logic signed [PSUM_BITWIDTH-1:0] prod_ext;
   logic signed [PSUM_BITWIDTH-1:0] acc_q;
   logic signed [PSUM_BITWIDTH-1:0] acc_next;
   logic                            step_sat;

   assign prod_d   = PROD_W'(iact_head) * PROD_W'(wght_rd);
   assign prod_ext = PSUM_BITWIDTH'(prod_q);

`ifdef PE_MAC_ACC_SATURATE_EN
   localparam logic signed [PSUM_BITWIDTH-1:0] PSUM_MAX = {1'b0, {(PSUM_BITWIDTH-1){1'b1}}};
   localparam logic signed [PSUM_BITWIDTH-1:0] PSUM_MIN = {1'b1, {(PSUM_BITWIDTH-1){1'b0}}};

   logic signed [PSUM_BITWIDTH:0] sum_wide;
   logic                          sat_q;

   // One guard bit: overflow when the two top bits of the sum disagree,
   // and the guard bit then carries the true sign of the result.
   assign sum_wide = {acc_q[PSUM_BITWIDTH-1], acc_q} + {prod_ext[PSUM_BITWIDTH-1], prod_ext};
   assign step_sat = (sum_wide[PSUM_BITWIDTH] != sum_wide[PSUM_BITWIDTH-1]);

   always_comb begin
      acc_next = sum_wide[PSUM_BITWIDTH-1:0];
      if (step_sat) acc_next = sum_wide[PSUM_BITWIDTH] ? PSUM_MIN : PSUM_MAX;
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         sat_q <= 1'b0;
      end else if (job_start) begin
         sat_q <= 1'b0;
      end else if (prod_vld_q && step_sat) begin
         sat_q <= 1'b1;
      end
   end

   assign psum_sat = sat_q;
`else
   assign step_sat = 1'b0;
   assign acc_next = acc_q + prod_ext;
`endif

   always_ff @(posedge clk) begin
      if (!rstN) begin
         ch_cnt_q   <= '0;
         n_q        <= '0;
         prod_q     <= '0;
         prod_vld_q <= 1'b0;
         acc_q      <= '0;
         psum_dout  <= '0;
      end else if (job_start) begin
         n_q        <= n_eff;
         ch_cnt_q   <= '0;
         acc_q      <= '0;
         prod_vld_q <= 1'b0;
      end else begin
         prod_vld_q <= pop;
         if (pop) begin
            prod_q   <= prod_d;
            ch_cnt_q <= ch_cnt_q + CH_ONE;
         end
         if (prod_vld_q) acc_q <= acc_next;
         // The output register loads only with the final sum, so it
         // holds the previous result through the next job.
         if (state_q == S_FLUSH) psum_dout <= acc_next;
      end
   end

   // ---------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rstN) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      psum_valid = 1'b0;
      busy       = 1'b1;
      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_d = S_ACCUM;
         end
         S_ACCUM: begin
            if (last_pop) state_d = S_FLUSH;
         end
         S_FLUSH: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            psum_valid = 1'b1;
            if (psum_ready) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule
